// File: rtl/register_file_component_pkg.sv
// ----------------------------------------------------------------------------
// register_file_component_pkg
//   Shared definitions for the register file:
//     - default data and address widths
//     - the sequencer state encoding (CLEAR = 0, RUN = 1)
// ----------------------------------------------------------------------------
package register_file_component_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage : register_file_component_pkg

// File: rtl/register_file_component_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of the register file. It selects between the
//   stored word and the in-flight write-back value, and masks the result to 0
//   for register 0 and while the clear sequence is running.
//
//   Ports
//     i_rd_addr  : register address being read
//     i_rd_word  : stored contents of that register (from the array)
//     i_busy     : clear sequence active; output is forced to 0
//     i_wr_qual  : a write will commit on the next rising edge
//     i_wr_addr  : destination of that write
//     i_wr_data  : value of that write
//     o_rd_data  : read result (zero-cycle latency)
// ----------------------------------------------------------------------------
module regfile_read_port
    import register_file_component_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_word,
    input  logic              i_busy,
    input  logic              i_wr_qual,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic w_bypass;

    // i_wr_qual already excludes address 0, stall and busy, so an address
    // match is all that is needed here.
    assign w_bypass = i_wr_qual && (i_wr_addr == i_rd_addr);

    always_comb begin
        o_rd_data = i_rd_word;
        if (i_busy || (i_rd_addr == '0)) begin
            o_rd_data = '0;
        end else if (w_bypass) begin
            o_rd_data = i_wr_data;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file_component.sv
// ----------------------------------------------------------------------------
// register_file_component
//   2-read / 1-write register file with register 0 hard-wired to zero,
//   write-through bypass on both read ports and a post-reset clear sequence
//   that zeroes registers 1..2**ADDR_W-1, one per clock.
//
//   Ports
//     clk       : clock, all state changes on the rising edge
//     reset     : asynchronous, active-low reset
//     rs1_addr  : read port A address      rs1_data : read port A data
//     rs2_addr  : read port B address      rs2_data : read port B data
//     wr_en     : write-back enable
//     wr_addr   : write-back destination register
//     wr_data   : write-back value
//     stall     : suppresses the write (and its bypass) when high
//     busy      : high while the clear sequence runs
// ----------------------------------------------------------------------------
module register_file_component
    import register_file_component_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              stall,
    output logic              busy
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];

    rf_state_t         r_state;
    rf_state_t         w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_busy;
    logic              w_wr_qual;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer: next state. RUN is entered on the edge that clears the
    // last address and is then held until the next reset.
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_CLEAR) && (r_clr_cnt == LAST_ADDR)) begin
            w_state_next = ST_RUN;
        end
    end

    // Sequencer: outputs. Because reset forces CLEAR asynchronously, busy
    // is also high for the whole time reset is held, which masks the read
    // ports and blocks user writes without needing reset in the datapath.
    always_comb begin
        w_busy = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_busy = 1'b1;
        end
    end

    assign busy = w_busy;

    // Clear address counter, starts at 1 because register 0 is never stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= FIRST_ADDR;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register array: not reset, the clear sequence zeroes it instead.
    // ------------------------------------------------------------------
    assign w_wr_qual = wr_en && !stall && !w_busy && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_qual) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];

    assign w_rd_addr[0] = rs1_addr;
    assign w_rd_addr[1] = rs2_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            regfile_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_rd_port (
                .i_rd_addr (w_rd_addr[gi]),
                .i_rd_word (r_mem[w_rd_addr[gi]]),
                .i_busy    (w_busy),
                .i_wr_qual (w_wr_qual),
                .i_wr_addr (wr_addr),
                .i_wr_data (wr_data),
                .o_rd_data (w_rd_data[gi])
            );
        end
    endgenerate

    assign rs1_data = w_rd_data[0];
    assign rs2_data = w_rd_data[1];

endmodule : register_file_component
